// File: rtl/wb_exception_ctrl_if.sv
// Pipeline-latch-to-writeback bundle: latch fields in, register-file write port and
// upstream flush/block controls out.
interface wb_exception_ctrl_if;
  logic [1:0]  in_type;
  logic [2:0]  in_exception;
  logic [31:0] inALU;
  logic [31:0] inMEM;
  logic [31:0] ir_in;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        flush;
  logic        block;
  logic        busy;

  modport master (
    output in_type, in_exception, inALU, inMEM, ir_in,
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, flush, block, busy
  );

  modport slave (
    input  in_type, in_exception, inALU, inMEM, ir_in,
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, flush, block, busy
  );
endinterface

// File: rtl/wb_exception_ctrl.sv
// Writeback stage: drives the register-file write port and sequences an exception flush.
// Optional macro WB_EXC_COUNT_EN adds a saturating accepted-exception counter (exc_count).
module wb_exception_ctrl #(
  parameter int STATUS_REG   = 30,
  parameter int LINK_REG     = 31,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic               clock,
  input  logic               reset,
`ifdef WB_EXC_COUNT_EN
  output logic [15:0]        exc_count,
`endif
  wb_exception_ctrl_if.slave wb
);

  typedef enum logic [1:0] {IDLE, EXC, FLUSH} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [4:0]  reg_q;
  logic [31:0] data_q;
  logic        flush_q;
  logic        block_q;
  logic        busy_q;
`ifdef WB_EXC_COUNT_EN
  logic [15:0] exc_cnt_q;
`endif

  // Write target and data for a normal (exception-free) retirement.
  logic [4:0]  wr_reg_d;
  logic [31:0] wr_data_d;
  logic        wr_en_d;

  always_comb begin
    wr_reg_d  = wb.ir_in[26:22];
    wr_data_d = wb.inALU;
    unique case (wb.in_type)
      2'b10:   wr_data_d = wb.inMEM;
      2'b11:   wr_reg_d  = 5'(LINK_REG);
      default: ;
    endcase
    // Register 0 is hardwired; never let a write reach it.
    wr_en_d = (wb.in_type != 2'b00) && (wr_reg_d != 5'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      reg_q     <= 5'd0;
      data_q    <= 32'd0;
      flush_q   <= 1'b0;
      block_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef WB_EXC_COUNT_EN
      exc_cnt_q <= 16'd0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wb.in_exception != 3'd0) begin
            state_q <= EXC;
            we_q    <= 1'b1;
            reg_q   <= 5'(STATUS_REG);
            data_q  <= {29'd0, wb.in_exception};
            flush_q <= 1'b1;
            block_q <= 1'b1;
            busy_q  <= 1'b1;
`ifdef WB_EXC_COUNT_EN
            if (exc_cnt_q != 16'hFFFF) exc_cnt_q <= exc_cnt_q + 16'd1;
`endif
          end else begin
            we_q    <= wr_en_d;
            reg_q   <= wr_reg_d;
            data_q  <= wr_data_d;
            flush_q <= 1'b0;
            block_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        EXC: begin
          state_q <= FLUSH;
          cnt_q   <= 4'(FLUSH_CYCLES - 1);
          we_q    <= 1'b0;
        end
        FLUSH: begin
          // Latch contents are being squashed, so inputs (including exceptions) are ignored.
          we_q <= 1'b0;
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
            block_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb.ctrl_writeEnable = we_q;
  assign wb.ctrl_writeReg    = reg_q;
  assign wb.data_writeReg    = data_q;
  assign wb.flush            = flush_q;
  assign wb.block            = block_q;
  assign wb.busy             = busy_q;
`ifdef WB_EXC_COUNT_EN
  assign exc_count           = exc_cnt_q;
`endif

endmodule

// File: tb/tb_wb_exception_ctrl.sv
// Directed bench for wb_exception_ctrl: write port, exception flush sequence and reset abort.
module tb_wb_exception_ctrl;
  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
`ifdef WB_EXC_COUNT_EN
  logic [15:0] exc_count;
`endif

  wb_exception_ctrl_if wb ();

  wb_exception_ctrl dut (
    .clock    (clock),
    .reset    (reset),
`ifdef WB_EXC_COUNT_EN
    .exc_count(exc_count),
`endif
    .wb       (wb.slave)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] t, input logic [2:0] e, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem);
    wb.in_type      = t;
    wb.in_exception = e;
    wb.ir_in        = {5'd0, rd, 22'h2ABCD};
    wb.inALU        = alu;
    wb.inMEM        = mem;
  endtask

  task automatic chk_ctrl(input string tag, input logic f, input logic b, input logic bz);
    chk({tag, "_flush"}, {31'd0, wb.flush}, {31'd0, f});
    chk({tag, "_block"}, {31'd0, wb.block}, {31'd0, b});
    chk({tag, "_busy"},  {31'd0, wb.busy},  {31'd0, bz});
  endtask

  initial begin
    // Reset held two cycles with random inputs, including a nonzero exception.
    reset = 1'b1;
    drive(2'($urandom), 3'd6, 5'($urandom), $urandom, $urandom);
    step();
    drive(2'($urandom), 3'd1, 5'($urandom), $urandom, $urandom);
    step();
    chk("rst_we",   {31'd0, wb.ctrl_writeEnable}, 32'd0);
    chk("rst_reg",  {27'd0, wb.ctrl_writeReg}, 32'd0);
    chk("rst_data", wb.data_writeReg, 32'd0);
    chk_ctrl("rst", 1'b0, 1'b0, 1'b0);
`ifdef WB_EXC_COUNT_EN
    chk("rst_cnt", {16'd0, exc_count}, 32'd0);
`endif

    reset = 1'b0;
    drive(2'b00, 3'd0, 5'd4, 32'h1111_1111, 32'h2222_2222);
    step();
    chk("none_we", {31'd0, wb.ctrl_writeEnable}, 32'd0);
    chk_ctrl("none", 1'b0, 1'b0, 1'b0);

    // Back-to-back ALU / load / rd0 / link writes.
    drive(2'b01, 3'd0, 5'd5, 32'h0000_1234, 32'h0);
    step();
    chk("alu_we",   {31'd0, wb.ctrl_writeEnable}, 32'd1);
    chk("alu_reg",  {27'd0, wb.ctrl_writeReg}, 32'd5);
    chk("alu_data", wb.data_writeReg, 32'h0000_1234);

    drive(2'b10, 3'd0, 5'd7, 32'h5555_5555, 32'hDEAD_BEEF);
    step();
    chk("ld_we",   {31'd0, wb.ctrl_writeEnable}, 32'd1);
    chk("ld_reg",  {27'd0, wb.ctrl_writeReg}, 32'd7);
    chk("ld_data", wb.data_writeReg, 32'hDEAD_BEEF);

    drive(2'b01, 3'd0, 5'd0, 32'h0000_9999, 32'h0);
    step();
    chk("r0_we", {31'd0, wb.ctrl_writeEnable}, 32'd0);

    drive(2'b11, 3'd0, 5'd3, 32'h0000_0040, 32'hFFFF_0000);
    step();
    chk("lnk_we",   {31'd0, wb.ctrl_writeEnable}, 32'd1);
    chk("lnk_reg",  {27'd0, wb.ctrl_writeReg}, 32'd31);
    chk("lnk_data", wb.data_writeReg, 32'h0000_0040);

    // Exception overrides an rd=9 ALU write.
    drive(2'b01, 3'd3, 5'd9, 32'h0000_0777, 32'h0);
    step();
    chk("exc_we",   {31'd0, wb.ctrl_writeEnable}, 32'd1);
    chk("exc_reg",  {27'd0, wb.ctrl_writeReg}, 32'd30);
    chk("exc_data", wb.data_writeReg, 32'd3);
    chk_ctrl("exc", 1'b1, 1'b1, 1'b1);

    // Squashed exception presented throughout the flush; three more flush cycles expected.
    drive(2'b01, 3'd5, 5'd9, 32'h0000_0888, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fl%0d_we", i), {31'd0, wb.ctrl_writeEnable}, 32'd0);
      chk_ctrl($sformatf("fl%0d", i), 1'b1, 1'b1, 1'b1);
    end
    step();
    chk("end_we", {31'd0, wb.ctrl_writeEnable}, 32'd0);
    chk_ctrl("end", 1'b0, 1'b0, 1'b0);
    drive(2'b00, 3'd0, 5'd9, 32'h0, 32'h0);
    step();
    chk("idle_we", {31'd0, wb.ctrl_writeEnable}, 32'd0);
    chk_ctrl("idle", 1'b0, 1'b0, 1'b0);
`ifdef WB_EXC_COUNT_EN
    chk("cnt1", {16'd0, exc_count}, 32'd1);
`endif

    // Second exception, aborted by reset in the second FLUSH cycle.
    drive(2'b00, 3'd2, 5'd1, 32'h0, 32'h0);
    step();
    chk("exc2_data", wb.data_writeReg, 32'd2);
    chk_ctrl("exc2", 1'b1, 1'b1, 1'b1);
    drive(2'b00, 3'd0, 5'd1, 32'h0, 32'h0);
    step();
    step();
    chk_ctrl("fl2b", 1'b1, 1'b1, 1'b1);
`ifdef WB_EXC_COUNT_EN
    chk("cnt2", {16'd0, exc_count}, 32'd2);
`endif
    reset = 1'b1;
    step();
    chk("abort_we", {31'd0, wb.ctrl_writeEnable}, 32'd0);
    chk_ctrl("abort", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(2'b01, 3'd0, 5'd12, 32'h0000_ABCD, 32'h0);
    step();
    chk("post_we",   {31'd0, wb.ctrl_writeEnable}, 32'd1);
    chk("post_reg",  {27'd0, wb.ctrl_writeReg}, 32'd12);
    chk("post_data", wb.data_writeReg, 32'h0000_ABCD);
    chk_ctrl("post", 1'b0, 1'b0, 1'b0);
`ifdef WB_EXC_COUNT_EN
    chk("cnt_rst", {16'd0, exc_count}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_exception_ctrl.md
Name: wb_exception_ctrl

Overview:
- Writeback-end consumer of the memory/writeback pipeline latch.
- Takes the latched instruction type, exception code, ALU result, memory data and instruction word, and produces the register-file write port.
- On a nonzero exception code, writes the code to the status register and sequences a multi-cycle pipeline flush/block back to the upstream latches (drives their `flush` and `block` inputs).

Parameters:
- STATUS_REG, 30, register index receiving exception codes
- LINK_REG, 31, register index for link (type 11) writes
- FLUSH_CYCLES, 3, cycles `flush` is held after an exception (legal range 1..15)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_type  in  2  instruction type from latch: 00 none, 01 ALU write, 10 load write, 11 link write
- in_exception  in  3  exception code from latch; 0 = none
- inALU  in  32  ALU result
- inMEM  in  32  memory read data
- ir_in  in  32  instruction word; rd = ir_in[26:22]
- ctrl_writeEnable  out  1  register-file write enable
- ctrl_writeReg  out  5  register-file write index
- data_writeReg  out  32  register-file write data
- flush  out  1  clear to upstream pipeline latches
- block  out  1  hold to upstream latches and PC
- busy  out  1  high while not in IDLE

Behaviour:
- All outputs registered; one-cycle latency from inputs to write port.
- Reset (synchronous, active-high): state IDLE, counter 0, and all outputs 0.
- Reset mid-flush aborts the sequence and returns to IDLE the next edge.
- FSM states: IDLE, EXC, FLUSH.
- IDLE, in_exception == 0, by in_type:
  - 00: writeEnable = 0.
  - 01: writeReg = rd, data = inALU.
  - 10: writeReg = rd, data = inMEM.
  - 11: writeReg = LINK_REG, data = inALU.
- Zero-register rule: any computed writeReg of 0 forces writeEnable = 0. data/writeReg still update; don't-care for checking.
- IDLE, in_exception != 0:
  - Exception wins over any in_type write; the rd write is suppressed.
  - Next edge: writeEnable = 1, writeReg = STATUS_REG, data = zero-extended code, flush = 1, block = 1.
  - State → EXC.
- EXC:
  - One cycle, then → FLUSH with counter = FLUSH_CYCLES-1.
  - flush and block stay 1; writeEnable drops to 0.
- FLUSH:
  - flush = 1, block = 1, writeEnable = 0.
  - Counter decrements each cycle; inputs are ignored (latch contents are being cleared).
  - When counter == 0, next edge → IDLE with flush = 0, block = 0.
- Total flush assertion: exactly 1 + FLUSH_CYCLES cycles per exception.
- An exception arriving while busy is ignored: upstream is being flushed, so it is treated as squashed.
- busy = (state != IDLE), registered with the state.
- Back-to-back writes in IDLE are sustained every cycle with no bubbles.

Optional Feature:
- Macro WB_EXC_COUNT_EN.
- When defined:
  - Adds output exc_count [15:0], a saturating count of accepted exceptions (those entering EXC).
  - Holds at 16'hFFFF once reached; cleared by reset; increments on the same edge the state enters EXC.
- When undefined: the port and logic are absent; behaviour otherwise identical.

Test Plan:
- Reset asserted 2 cycles with random inputs → all outputs 0, busy 0; release with type 00 → writeEnable stays 0.
- ir_in rd = 5, type 01, inALU = 32'h0000_1234, exc 0 → next cycle we = 1, writeReg = 5, data = 32'h1234. Repeat with type 10, inMEM = 32'hDEAD_BEEF, rd = 7 → we = 1, reg 7, data DEADBEEF. rd = 0 → we = 0.
- type 11, inALU = 32'h40 → we = 1, writeReg = 31, data = 32'h40.
- type 01, rd = 9, exc = 3 → next cycle we = 1, writeReg = 30, data = 3, flush = 1. With FLUSH_CYCLES = 3: flush/block high exactly 4 cycles, busy high 4 cycles; reg 9 is never written.
- During FLUSH, drive exc = 5, type 01 → no write, flush length unchanged, returns to IDLE. With WB_EXC_COUNT_EN: exc_count = 1.
- Reset asserted in second FLUSH cycle → next edge flush = 0, block = 0, busy = 0; a following type 01 write completes normally.
